// File: rtl/cnn_pkg.sv
// Shared types and constants for the 3x3 convolution datapath.
// Combinational only; no latency or backpressure.
package cnn_pkg;

  localparam int KERNEL_TAPS    = 9;
  localparam int DATA_WIDTH_DEF = 16;

  typedef logic signed [DATA_WIDTH_DEF-1:0] pix_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  function automatic int prod_width(input int dw);
    return 2 * dw;
  endfunction

  // Nine products need 4 guard bits so the sum can never wrap.
  function automatic int acc_width(input int dw);
    return 2 * dw + 4;
  endfunction

endpackage

// File: rtl/line_buffer_3row.sv
// Two row delay lines plus a 3x3 window; taps valid the cycle after the accepting edge.
// Raster position counters advance only on pix_vld; no backpressure.
module line_buffer_3row
  import cnn_pkg::*;
#(
  parameter int DW         = 16,
  parameter int IMG_WIDTH  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int CW         = $clog2(IMG_WIDTH),
  parameter int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DW-1:0]             pix,
  input  logic                      pix_vld,
  output logic [KERNEL_TAPS*DW-1:0] taps,
  output logic [CW-1:0]             col,
  output logic [RW-1:0]             row
);

  logic [DW-1:0] lb0 [IMG_WIDTH];
  logic [DW-1:0] lb1 [IMG_WIDTH];
  logic [DW-1:0] win [3][3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_vld) begin
      if (col == CW'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // lb0 holds the previous row, lb1 the row before it, both indexed by column.
  always_ff @(posedge clk) begin
    if (pix_vld) begin
      lb0[col] <= pix;
      lb1[col] <= lb0[col];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (pix_vld) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[col];
      win[1][2] <= lb0[col];
      win[2][2] <= pix;
    end
  end

  for (genvar k = 0; k < KERNEL_TAPS; k++) begin : g_taps
    assign taps[k*DW +: DW] = win[k/3][k%3];
  end

endmodule

// File: rtl/conv2d_3x3_strided.sv
// Streaming 3x3 strided convolution, Q-format MAC with round/saturate; 3-cycle latency, no backpressure.
// Optional ReLU on the output when CONV2D_RELU_EN is defined.
module conv2d_3x3_strided
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IMG_WIDTH  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int STRIDE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  input  logic                  Kernel_Wr,
  input  logic [3:0]            Kernel_Addr,
  input  logic [DATA_WIDTH-1:0] Kernel_Data,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Frame_Done,
  output logic                  Busy
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = prod_width(DATA_WIDTH);
  localparam int AW = acc_width(DATA_WIDTH);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic signed [AW-1:0] RND = AW'(1) << (FRAC_BITS - 1);

  if (STRIDE != 1 && STRIDE != 2) begin : g_bad_stride
    $error("conv2d_3x3_strided: STRIDE must be 1 or 2");
  end

  logic [1:0]                  state;
  logic [KERNEL_TAPS*DW-1:0]   taps;
  logic [CW-1:0]               col;
  logic [RW-1:0]               row;
  logic signed [DW-1:0]        tap  [KERNEL_TAPS];
  logic [DW-1:0]               coef [KERNEL_TAPS];
  logic signed [PW-1:0]        s1_prod [KERNEL_TAPS];
  logic signed [AW-1:0]        acc_sum, s2_sum, rnd, shf;
  logic [DW-1:0]               sat_val, res;
  logic                        row_ph, col_ph, win_hit, last_pix, ovf;
  logic                        s0_vld, s0_last, s1_vld, s1_last, s2_vld, s2_last;

  line_buffer_3row #(
    .DW(DW), .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .CW(CW), .RW(RW)
  ) u_lb (
    .clk(clk), .rst(rst), .pix(Data_In), .pix_vld(Valid_In),
    .taps(taps), .col(col), .row(row)
  );

  for (genvar g = 0; g < KERNEL_TAPS; g++) begin : g_tap
    assign tap[g] = $signed(taps[g*DW +: DW]);
  end

  // With stride 2, (n-2) mod 2 == 0 reduces to n being even.
  assign row_ph   = (STRIDE == 1) || !row[0];
  assign col_ph   = (STRIDE == 1) || !col[0];
  assign win_hit  = Valid_In && (row >= RW'(2)) && (col >= CW'(2)) && row_ph && col_ph;
  assign last_pix = Valid_In && (row == RW'(IMG_HEIGHT - 1)) && (col == CW'(IMG_WIDTH - 1));
  assign Busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (Valid_In) state <= RUN;
        RUN:     if (last_pix) state <= DRAIN;
        DRAIN:   if (Valid_In) state <= RUN;
                 else if (s2_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KERNEL_TAPS; i++) coef[i] <= '0;
    end else if (Kernel_Wr && (state == IDLE) && (Kernel_Addr < 4'd9)) begin
      coef[Kernel_Addr] <= Kernel_Data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_vld     <= 1'b0;
      s0_last    <= 1'b0;
      s1_vld     <= 1'b0;
      s1_last    <= 1'b0;
      s2_vld     <= 1'b0;
      s2_last    <= 1'b0;
      Valid_Out  <= 1'b0;
      Frame_Done <= 1'b0;
      Data_Out   <= '0;
    end else begin
      s0_vld     <= win_hit;
      s0_last    <= last_pix;
      s1_vld     <= s0_vld;
      s1_last    <= s0_last;
      s2_vld     <= s1_vld;
      s2_last    <= s1_last;
      Valid_Out  <= s2_vld;
      Frame_Done <= s2_last;
      if (s2_vld) Data_Out <= res;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < KERNEL_TAPS; i++)
      s1_prod[i] <= PW'(tap[i]) * PW'($signed(coef[i]));
    s2_sum <= acc_sum;
  end

  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < KERNEL_TAPS; i++)
      acc_sum = acc_sum + AW'(s1_prod[i]);
  end

  // Overflow when the bits above the output sign are not a pure sign extension.
  always_comb begin
    rnd     = s2_sum + RND;
    shf     = rnd >>> FRAC_BITS;
    ovf     = !((&shf[AW-1:DW-1]) || !(|shf[AW-1:DW-1]));
    sat_val = shf[DW-1:0];
    if (ovf) sat_val = shf[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

`ifdef CONV2D_RELU_EN
  assign res = sat_val[DW-1] ? '0 : sat_val;
`else
  assign res = sat_val;
`endif

endmodule

// File: tb/tb_conv2d_3x3_strided.sv
// Scoreboard bench: stride-1 and stride-2 instances on a shared 5x5 pixel stream.
module tb_conv2d_3x3_strided;
  import cnn_pkg::*;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int W  = 5;
  localparam int H  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] Data_In, Kernel_Data;
  logic          Valid_In, Kernel_Wr;
  logic [3:0]    Kernel_Addr;
  logic [DW-1:0] do1, do2;
  logic          vo1, vo2, fd1, fd2, busy1, busy2;

  always #5 clk = ~clk;

  conv2d_3x3_strided #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .IMG_WIDTH(W), .IMG_HEIGHT(H), .STRIDE(1)) u_dut1 (
    .clk(clk), .rst(rst), .Data_In(Data_In), .Valid_In(Valid_In), .Kernel_Wr(Kernel_Wr),
    .Kernel_Addr(Kernel_Addr), .Kernel_Data(Kernel_Data), .Data_Out(do1), .Valid_Out(vo1),
    .Frame_Done(fd1), .Busy(busy1));

  conv2d_3x3_strided #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .IMG_WIDTH(W), .IMG_HEIGHT(H), .STRIDE(2)) u_dut2 (
    .clk(clk), .rst(rst), .Data_In(Data_In), .Valid_In(Valid_In), .Kernel_Wr(Kernel_Wr),
    .Kernel_Addr(Kernel_Addr), .Kernel_Data(Kernel_Data), .Data_Out(do2), .Valid_Out(vo2),
    .Frame_Done(fd2), .Busy(busy2));

  typedef struct {
    int dat;
    int cyc;
    int fd;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   img [H][W];
  int   kern [9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int model(input int r, input int c);
    longint acc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += longint'(img[r-2+i][c-2+j]) * longint'(kern[i*3+j]);
    acc = (acc + longint'(1 << (FB - 1))) >>> FB;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`ifdef CONV2D_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return int'(acc);
  endfunction

  // Called while the pixel is on the bus; it is accepted on the next edge, output 3 edges later.
  task automatic push(input int r, input int c);
    exp_t e;
    if (r >= 2 && c >= 2) begin
      e.dat = model(r, c);
      e.cyc = cyc + 4;
      e.fd  = (r == H-1 && c == W-1) ? 1 : 0;
      q1.push_back(e);
      if ((r % 2) == 0 && (c % 2) == 0) q2.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (vo1) begin
      if (q1.size() == 0) chk("s1_unexpected_valid", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("s1_data", int'($signed(do1)), e1.dat);
        chk("s1_latency", cyc, e1.cyc);
        chk("s1_frame_done", int'(fd1), e1.fd);
      end
    end else if (fd1) chk("s1_frame_done_alone", int'(fd1), 0);
    if (vo2) begin
      if (q2.size() == 0) chk("s2_unexpected_valid", 1, 0);
      else begin
        e2 = q2.pop_front();
        chk("s2_data", int'($signed(do2)), e2.dat);
        chk("s2_latency", cyc, e2.cyc);
        chk("s2_frame_done", int'(fd2), e2.fd);
      end
    end else if (fd2) chk("s2_frame_done_alone", int'(fd2), 0);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_coef(input int a, input int d);
    Kernel_Wr   = 1'b1;
    Kernel_Addr = a[3:0];
    Kernel_Data = d[DW-1:0];
    if (a <= 8) kern[a] = d;
    idle(1);
    Kernel_Wr = 1'b0;
  endtask

  task automatic drive_pix(input int r, input int c, input int p);
    Data_In   = p[DW-1:0];
    Valid_In  = 1'b1;
    img[r][c] = p;
    push(r, c);
    idle(1);
    Valid_In  = 1'b0;
    Kernel_Wr = 1'b0;
  endtask

  // kind 0: ramp col*256, else constant val. wr_at injects a kernel write, rst_at a reset.
  task automatic run_frame(input int kind, input int val, input int gap, input int wr_at, input int rst_at);
    int p;
    for (int idx = 0; idx < W*H; idx++) begin
      p = (kind == 0) ? (idx % W) * 256 : val;
      if (idx == rst_at) begin
        Data_In  = p[DW-1:0];
        Valid_In = 1'b1;
        rst      = 1'b0;
        q1.delete();
        q2.delete();
        for (int k = 0; k < 9; k++) kern[k] = 0;
        idle(3);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_valid_out", int'(vo1), 0);
        chk("rst_data_out", int'(do1), 0);
        chk("rst_frame_done", int'(fd2), 0);
        Valid_In = 1'b0;
        rst      = 1'b1;
        idle(8);
        chk("rst_busy_after", int'(busy2), 0);
        return;
      end
      if (idx == wr_at) begin
        Kernel_Wr   = 1'b1;
        Kernel_Addr = 4'd0;
        Kernel_Data = '0;
      end
      drive_pix(idx / W, idx % W, p);
      if (gap != 0) idle(1);
    end
    idle(8);
    chk("s1_outputs_left", q1.size(), 0);
    chk("s2_outputs_left", q2.size(), 0);
    chk("busy_after_drain", int'(busy1), 0);
  endtask

  initial begin
    int sobel [9];
    sobel = '{256, 0, -256, 512, 0, -512, 256, 0, -256};
    rst = 1'b0; Valid_In = 1'b0; Kernel_Wr = 1'b0; Kernel_Addr = '0;
    Kernel_Data = '0; Data_In = '0;
    for (int k = 0; k < 9; k++) kern[k] = 0;
    idle(3);
    chk("reset_data_out", int'(do1), 0);
    chk("reset_valid_out", int'(vo1), 0);
    chk("reset_frame_done", int'(fd1), 0);
    chk("reset_busy", int'(busy2), 0);
    rst = 1'b1;
    idle(2);

    for (int k = 0; k < 9; k++) wr_coef(k, sobel[k]);
    wr_coef(12, 1234);
    run_frame(0, 0, 0, -1, -1);
    run_frame(0, 0, 1, -1, -1);

    // Flipped kernel; tap 0 is written in the same cycle as the first pixel.
    for (int k = 1; k < 9; k++) wr_coef(k, -sobel[k]);
    Kernel_Wr = 1'b1; Kernel_Addr = 4'd0; Kernel_Data = 16'hFF00;
    kern[0] = -256;
    run_frame(0, 0, 0, -1, -1);
    run_frame(0, 0, 0, 7, -1);

    for (int k = 0; k < 9; k++) wr_coef(k, 256);
    run_frame(1, 32512, 0, -1, -1);
    run_frame(1, -32768, 0, -1, -1);

    run_frame(0, 0, 0, -1, 12);
    run_frame(0, 0, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/conv2d_3x3_strided.md
Name: conv2d_3x3_strided

Overview:
- Streaming 3x3 2D convolution on a raster-order pixel stream, one pixel per Valid_In beat.
- Generalised successor of the fixed-kernel stride-1 convolver:
  - signed fixed-point data of parametrised width
  - parametrised stride
  - runtime-loadable kernel
  - pipelined MAC with rounding and saturation
  - frame-done signalling
- Sits between the pixel source/DMA and the pooling/activation stage of the CNN datapath.

Parameters:
- DATA_WIDTH, 16, width of pixels, kernel coefficients and output (signed two's complement).
- FRAC_BITS, 8, fractional bits of the Q format shared by pixels, coefficients and output.
- IMG_WIDTH, 220, pixels per row (>=3).
- IMG_HEIGHT, 220, rows per frame (>=3).
- STRIDE, 1, horizontal and vertical stride. Legal values are 1 and 2; any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- Data_In  in  DATA_WIDTH  input pixel.
- Valid_In  in  1  Data_In valid this cycle. Gaps are allowed; there is no backpressure.
- Kernel_Wr  in  1  coefficient write strobe.
- Kernel_Addr  in  4  coefficient index 0..8, row-major (0 = top-left).
- Kernel_Data  in  DATA_WIDTH  coefficient value.
- Data_Out  out  DATA_WIDTH  convolution result.
- Valid_Out  out  1  Data_Out valid, one-cycle pulse per output pixel.
- Frame_Done  out  1  one-cycle pulse, same cycle as the last Valid_Out of a frame.
- Busy  out  1  high while the frame is in RUN or DRAIN.

Behaviour:
- Reset (rst=0, asynchronous):
  - Data_Out=0, Valid_Out=0, Frame_Done=0, Busy=0.
  - Row/column counters, pipeline valid bits and all nine coefficients cleared to 0.
  - State forced to IDLE.
  - Reset mid-frame discards all in-flight data; no Valid_Out follows until a new frame is supplied.
- Storage:
  - Two line buffers of IMG_WIDTH words hold the previous two rows.
  - A 3x3 register window shifts on each accepted pixel.
- Counters:
  - col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1 advance only on Valid_In.
  - col wraps to 0 and increments row.
- Window-valid condition, evaluated on the accepted pixel:
  - row>=2 and col>=2, and
  - (row-2) mod STRIDE==0 and (col-2) mod STRIDE==0.
  - Output grid is ((IMG_HEIGHT-3)/STRIDE+1) x ((IMG_WIDTH-3)/STRIDE+1), integer division. No padding.
- Pipeline (advances every cycle, independent of Valid_In), latency 3 cycles from the accepting clock edge to Valid_Out:
  - S1: nine signed products, each 2*DATA_WIDTH bits.
  - S2: sum of the nine products, 2*DATA_WIDTH+4 bits.
  - S3: add 2^(FRAC_BITS-1), arithmetic shift right by FRAC_BITS, saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- State machine:
  - IDLE -> RUN on the first accepted pixel.
  - RUN -> DRAIN after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted; counters return to 0.
  - DRAIN -> IDLE after the 3-cycle pipeline empties.
  - Frame_Done is asserted with the final output. If the last pixel creates no output (possible with STRIDE=2), Frame_Done is a standalone pulse 3 cycles after that pixel.
  - Valid_In during DRAIN starts the next frame: counters run, state goes to RUN, and in-flight outputs still complete.
- Kernel writes:
  - Accepted only in IDLE; ignored in RUN/DRAIN.
  - Kernel_Addr>8 is ignored.
  - Kernel_Wr and Valid_In in the same IDLE cycle: the write lands first, the pixel is accepted, and the new coefficient applies to the frame.

Optional Feature:
- Macro CONV2D_RELU_EN.
- Defined: S3 output is clamped to 0 when negative (ReLU after saturation). Latency unchanged.
- Undefined: signed result is output as-is.

Decomposition:
- Shared package cnn_pkg:
  - pixel/coefficient typedef of DATA_WIDTH
  - product and accumulator width constants
  - KERNEL_TAPS=9
  - state enum {IDLE, RUN, DRAIN}
- One natural sub-module, line_buffer_3row: the two row FIFOs plus the 3x3 window register. It outputs nine taps and the col/row counters. The MAC pipeline and FSM stay in the top module.

Test Plan:
- Coefficient load and ramp, STRIDE=1, DATA_WIDTH=16, FRAC_BITS=8, 5x5 frame:
  - Stimulus: load Sobel-x {256,0,-256,512,0,-512,256,0,-256}; pixel=col*256.
  - Required: 9 Valid_Out pulses, each Data_Out=-2048 (0xF800); Frame_Done with the 9th; first Valid_Out 3 cycles after pixel (2,2).
- Same frame with STRIDE=2: exactly 4 Valid_Out pulses of -2048, at windows ending (2,2), (2,4), (4,2), (4,4).
- Saturation:
  - Stimulus: all coefficients 256; all pixels 32512 (127.0).
  - Required: every Data_Out=32767. With all pixels -32768, every Data_Out=-32768.
- Stalls: Valid_In asserted on alternate cycles for the ramp frame -> identical values and count to the first case, each output 3 cycles after its pixel.
- Reset and kernel protection:
  - Stimulus: Kernel_Wr during RUN with Addr=0, Data=0; rst low at pixel 12; new frame after release.
  - Required: write ignored (outputs unchanged); no Valid_Out after reset; Busy=0; coefficients read as 0, so all outputs of the new frame are 0.
- CONV2D_RELU_EN defined: ramp frame -> 9 outputs of 0. Flipped-sign kernel -> 9 outputs of 2048.
